// File: rtl/store_ctrl_if.sv
// Store controller bus: request/response toward the main control unit plus
// the memory/MDR/B-register enables driven by the store sequencer.
interface store_ctrl_if;
  logic        st_req;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic        b_load;
  logic        mdr_load;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [1:0]  set_store_size_control;

  // main control unit side
  modport master (
    output st_req, st_op, st_addr,
    input  st_busy, st_done, st_err, b_load, mdr_load, mem_addr, mem_wr,
           set_store_size_control
  );

  // store sequencer side
  modport slave (
    input  st_req, st_op, st_addr,
    output st_busy, st_done, st_err, b_load, mdr_load, mem_addr, mem_wr,
           set_store_size_control
  );
endinterface

// File: rtl/store_ctrl_fsm.sv
// Store sequencer for sb/sh/sw. Sub-word stores do a read-modify-write
// (read word into MDR, then write the merged word); sw writes directly.
//
// state   | meaning
// IDLE    | waiting for st_req; only state where a request is sampled
// RD_WAIT | read address on the bus, counting down the memory read latency
// MDR_LD  | mem_rdata valid, capture it into MDR
// WRITE   | single write cycle with the latched address and store size
// DONE    | one-cycle completion pulse
// ERR     | one-cycle reject pulse (illegal op or misaligned address)
module store_ctrl_fsm #(
  parameter int MEM_RD_LAT  = 1,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic         clk,
  input logic         reset,
  store_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    MDR_LD  = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [3:0] RD_LAT = 4'(MEM_RD_LAT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [1:0]  op_q, op_nxt;
  logic        legal;
  logic        aligned;

  // request qualification: op 11 has no store-size encoding, alignment is optional
  always_comb begin
    legal   = (bus.st_op != 2'b11);
    aligned = 1'b1;
    if (CHECK_ALIGN) begin
      case (bus.st_op)
        2'b01:   aligned = ~bus.st_addr[0];
        2'b10:   aligned = (bus.st_addr[1:0] == 2'b00);
        default: aligned = 1'b1;
      endcase
    end
  end

  // state, latency counter and latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= 32'd0;
      op_q   <= 2'b10;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      op_q   <= op_nxt;
    end
  end

  // next-state logic; rejected requests leave addr_q/op_q untouched
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    op_nxt    = op_q;
    case (state)
      IDLE: begin
        if (bus.st_req) begin
          if (legal && aligned) begin
            addr_nxt = bus.st_addr;
            op_nxt   = bus.st_op;
            if (bus.st_op == 2'b10) begin
              state_nxt = WRITE;
            end else begin
              state_nxt = RD_WAIT;
              cnt_nxt   = RD_LAT;
            end
          end else begin
            state_nxt = ERR;
          end
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = MDR_LD;
      end
      MDR_LD:  state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state/registers; b_load is the only combinational path from st_req
  always_comb begin
    bus.st_busy                = (state != IDLE);
    bus.st_done                = (state == DONE);
    bus.st_err                 = (state == ERR);
    bus.mdr_load               = (state == MDR_LD);
    bus.mem_wr                 = (state == WRITE);
    bus.mem_addr               = addr_q;
    bus.set_store_size_control = op_q;
    bus.b_load                 = (state == IDLE) && bus.st_req && legal && aligned;
  end

endmodule

// File: tb/tb_store_ctrl_fsm.sv
// Scoreboard bench for store_ctrl_fsm: the stimulus side predicts every
// output event (cycle, address, store size) from the store rules and queues
// it; a negedge monitor pops and compares whenever the DUT asserts an output.
module tb_store_ctrl_fsm;
  localparam int LAT  = 3;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_ctrl_if bus();

  store_ctrl_fsm #(.MEM_RD_LAT(LAT), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // kind: 0 b_load, 1 mdr_load, 2 mem_wr, 3 st_done, 4 st_err
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [1:0]  ctrl;
  } ev_t;

  ev_t         sbq[$];
  bit          busy_exp[MAXC];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [1:0]  m_op = 2'b10;
  int          free_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int c, input logic [31:0] a, input logic [1:0] o);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = a;
    e.ctrl = o;
    sbq.push_back(e);
  endfunction

  function automatic void set_busy(input int from, input int to);
    for (int k = from; k <= to; k++) if (k < MAXC) busy_exp[k] = 1'b1;
  endfunction

  // reference: predicted response to a request accepted in cycle a
  function automatic void model_issue(input logic [1:0] op, input logic [31:0] addr, input int a);
    bit ok;
    ok = (op != 2'b11);
    if (op == 2'b01 && addr[0] != 1'b0) ok = 1'b0;
    if (op == 2'b10 && addr[1:0] != 2'b00) ok = 1'b0;
    if (!ok) begin
      push(4, a + 1, m_addr, m_op);
      set_busy(a + 1, a + 1);
      free_cyc = a + 2;
    end else begin
      push(0, a, m_addr, m_op);
      m_addr = addr;
      m_op   = op;
      if (op == 2'b10) begin
        push(2, a + 1, m_addr, m_op);
        push(3, a + 2, m_addr, m_op);
        set_busy(a + 1, a + 2);
        free_cyc = a + 3;
      end else begin
        push(1, a + LAT + 1, m_addr, m_op);
        push(2, a + LAT + 2, m_addr, m_op);
        push(3, a + LAT + 3, m_addr, m_op);
        set_busy(a + 1, a + LAT + 3);
        free_cyc = a + LAT + 4;
      end
    end
  endfunction

  // monitor: match every asserted output against the head of the scoreboard
  always @(negedge clk) begin
    logic [4:0] act;
    ev_t        e;
    if (mon_en) begin
      act = {bus.st_err, bus.st_done, bus.mem_wr, bus.mdr_load, bus.b_load};
      for (int k = 0; k < 5; k++) begin
        if (act[k]) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d actual=1 required=0 (cycle %0d)", k, cyc);
          end else begin
            e = sbq.pop_front();
            chk($sformatf("event_kind@%0d", e.cyc), k, e.kind);
            chk($sformatf("event_cycle k%0d", k), cyc, e.cyc);
            chk($sformatf("mem_addr k%0d", k), bus.mem_addr, e.addr);
            chk($sformatf("store_size k%0d", k), {30'd0, bus.set_store_size_control}, {30'd0, e.ctrl});
          end
        end
      end
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event kind=%0d actual=0 required=1 (cycle %0d)", e.kind, e.cyc);
      end
      chk("st_busy", {31'd0, bus.st_busy}, {31'd0, (cyc < MAXC) ? busy_exp[cyc] : 1'b0});
      chk("done_err_excl", {31'd0, bus.st_done & bus.st_err}, 32'd0);
    end
  end

  task automatic chk_reset();
    chk("rst_busy", {31'd0, bus.st_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.st_done}, 32'd0);
    chk("rst_err", {31'd0, bus.st_err}, 32'd0);
    chk("rst_b_load", {31'd0, bus.b_load}, 32'd0);
    chk("rst_mdr_load", {31'd0, bus.mdr_load}, 32'd0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_size", {30'd0, bus.set_store_size_control}, 32'd2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free();
    while (cyc < free_cyc) step();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr);
    wait_free();
    bus.st_req  = 1'b1;
    bus.st_op   = op;
    bus.st_addr = addr;
    model_issue(op, addr, cyc);
    step();
    bus.st_req  = 1'b0;
    bus.st_op   = 2'($urandom);
    bus.st_addr = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  op;
    int          a0;
    int          guard;
    bus.st_req  = 1'b0;
    bus.st_op   = 2'b00;
    bus.st_addr = 32'd0;
    for (int k = 0; k < MAXC; k++) busy_exp[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset();
    mon_en = 1'b1;

    issue(2'b10, 32'h10);
    issue(2'b00, 32'h20);
    issue(2'b01, 32'h22);
    issue(2'b11, 32'h40);
    issue(2'b01, 32'h21);
    issue(2'b10, 32'h22);
    issue(2'b00, 32'h33);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      op = 2'($urandom_range(0, 3));
      issue(op, a);
      if ($urandom_range(0, 2) == 0) begin
        bus.st_req = 1'b1;
        bus.st_op  = 2'($urandom);
        step();
        bus.st_req = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // reset while the sb read is in flight: the pending events must never appear
    issue(2'b00, 32'h80);
    step();
    reset = 1'b1;
    while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
    for (int k = cyc + 1; k < MAXC; k++) busy_exp[k] = 1'b0;
    m_addr = 32'd0;
    m_op   = 2'b10;
    step();
    reset = 1'b0;
    chk_reset();
    free_cyc = cyc;

    // held sw request: accepted every third cycle, intermediate samples dropped
    wait_free();
    a0 = cyc;
    bus.st_req  = 1'b1;
    bus.st_op   = 2'b10;
    bus.st_addr = 32'h100;
    for (int k = 0; k < 4; k++) model_issue(2'b10, 32'h100, a0 + 3 * k);
    repeat (12) step();
    bus.st_req = 1'b0;

    issue(2'b01, 32'h202);
    issue(2'b10, 32'h300);

    guard = 0;
    while (sbq.size() > 0 && guard < 200) begin
      step();
      guard++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0 pending events", sbq.size());
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
